// File: rtl/exe_hazard_ctrl_if.sv
// Hazard controller bus: ID-stage instruction info and freeze request in,
// pipeline enables, flush/bubble controls and EX forwarding selects out.
interface exe_hazard_ctrl_if #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_branch_taken;
  logic             mem_stall;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic [CNT_W-1:0] stall_count;

  // Pipeline side: presents the ID instruction, consumes the controls
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, id_branch_taken, mem_stall,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           ex_fwd_a, ex_fwd_b, stall_count
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, id_branch_taken, mem_stall,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           ex_fwd_a, ex_fwd_b, stall_count
  );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline.
// Tracks destinations of the EX/MEM/WB instructions, produces registered
// EX operand-forwarding selects and combinational stall/flush/enable controls.
module exe_hazard_ctrl #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  exe_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WBBYP = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } sb_t;

  sb_t              ex_q, ex_d;
  sb_t              mem_q, mem_d;
  sb_t              wb_q, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ex_hit_a, ex_hit_b;
  logic             mem_hit_a, mem_hit_b;
  logic             wb_hit_a, wb_hit_b;
  logic             load_use;
  logic             bubble;
  logic [1:0]       sel_a, sel_b;

  logic             pc_write_c, ifid_write_c, ifid_flush_c;
  logic             idex_write_c, idex_bubble_c;

  // A stage produces the register an ID source actually reads (R0 excluded)
  function automatic logic match(input sb_t e, input logic [REG_W-1:0] rs,
                                 input logic use_rs);
    return e.valid && e.regwrite && (e.rd == rs) && (rs != '0) && use_rs;
  endfunction

  // Youngest producer wins; a load still in EX cannot supply its data
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic ex_load,
                                         input logic hit_mem, input logic hit_wb);
    if (hit_ex && !ex_load) return FWD_EXMEM;
    else if (hit_mem)       return FWD_MEMWB;
    else if (hit_wb)        return FWD_WBBYP;
    else                    return FWD_RF;
  endfunction

  // Hazard detection and forward-select computation for the ID instruction
  always_comb begin
    ex_hit_a  = match(ex_q,  bus.id_rs1, bus.id_use_rs1);
    ex_hit_b  = match(ex_q,  bus.id_rs2, bus.id_use_rs2);
    mem_hit_a = match(mem_q, bus.id_rs1, bus.id_use_rs1);
    mem_hit_b = match(mem_q, bus.id_rs2, bus.id_use_rs2);
    wb_hit_a  = match(wb_q,  bus.id_rs1, bus.id_use_rs1);
    wb_hit_b  = match(wb_q,  bus.id_rs2, bus.id_use_rs2);
    load_use  = bus.id_valid && ex_q.valid && ex_q.memread && (ex_hit_a || ex_hit_b);
    bubble    = load_use || !bus.id_valid;
    sel_a     = fwd_sel(ex_hit_a, ex_q.memread, mem_hit_a, wb_hit_a);
    sel_b     = fwd_sel(ex_hit_b, ex_q.memread, mem_hit_b, wb_hit_b);
  end

  // Pipeline enable/flush/bubble controls by priority
  always_comb begin
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_write_c  = 1'b1;
    idex_bubble_c = 1'b0;
    if (reset) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (bus.mem_stall) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_write_c  = 1'b0;
    end else if (load_use) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
    end else if (bus.id_branch_taken) begin
      ifid_flush_c  = 1'b1;
    end
  end

  // Scoreboard advance, forward-select capture and stall counting
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (!bus.mem_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble) begin
        // a bubble carries no producer and no operand selects
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end else begin
        ex_d.valid    = 1'b1;
        ex_d.rd       = bus.id_rd;
        ex_d.regwrite = bus.id_regwrite;
        ex_d.memread  = bus.id_memread;
        fwd_a_d       = sel_a;
        fwd_b_d       = sel_b;
      end
      if (load_use && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.ifid_write  = ifid_write_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_write  = idex_write_c;
  assign bus.idex_bubble = idex_bubble_c;
  assign bus.ex_fwd_a    = fwd_a_q;
  assign bus.ex_fwd_b    = fwd_b_q;
  assign bus.stall_count = cnt_q;

endmodule
